// File: rtl/ldtu_bsl_calib.sv
// rtl/ldtu_bsl_calib.sv - baseline calibration sequencer: settle, average both gain channels, load 8-bit baselines
// Optional LDTU_BSL_SAT_FLAG_EN builds the saturation flags; otherwise sat_flag is tied low.
module ldtu_bsl_calib #(
    parameter int Nbits_12   = 12,
    parameter int Nbits_8    = 8,
    parameter int NSAMP_LOG2 = 4,
    parameter int SETTLE     = 8
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                sample_valid,
    input  logic [Nbits_12-1:0] DATA12_g01,
    input  logic [Nbits_12-1:0] DATA12_g10,
    output logic [Nbits_8-1:0]  BSL_VAL_g01,
    output logic [Nbits_8-1:0]  BSL_VAL_g10,
    output logic                busy,
    output logic                done,
    output logic [1:0]          sat_flag
);

    localparam int AW = Nbits_12 + NSAMP_LOG2;
    localparam int CW = NSAMP_LOG2 + 1;
    localparam logic [CW-1:0]      SAMP_LAST   = CW'((1 << NSAMP_LOG2) - 1);
    localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [Nbits_8-1:0] BSL_MAX     = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCUM,
        S_LOAD
    } state_t;

    state_t              state_q;
    logic [7:0]          settle_cnt_q;
    logic [CW-1:0]       samp_cnt_q;
    logic [AW-1:0]       acc_g01_q;
    logic [AW-1:0]       acc_g10_q;
    logic [Nbits_8-1:0]  bsl_g01_q;
    logic [Nbits_8-1:0]  bsl_g10_q;
    logic                done_q;

    // Mean is the accumulator with the log2 sample count shifted off (truncating divide).
    logic [Nbits_12-1:0] mean_g01;
    logic [Nbits_12-1:0] mean_g10;
    logic                ovf_g01;
    logic                ovf_g10;
    logic [Nbits_8-1:0]  clamp_g01;
    logic [Nbits_8-1:0]  clamp_g10;

    assign mean_g01  = acc_g01_q[AW-1:NSAMP_LOG2];
    assign mean_g10  = acc_g10_q[AW-1:NSAMP_LOG2];
    assign ovf_g01   = |mean_g01[Nbits_12-1:Nbits_8];
    assign ovf_g10   = |mean_g10[Nbits_12-1:Nbits_8];
    assign clamp_g01 = ovf_g01 ? BSL_MAX : mean_g01[Nbits_8-1:0];
    assign clamp_g10 = ovf_g10 ? BSL_MAX : mean_g10[Nbits_8-1:0];

`ifdef LDTU_BSL_SAT_FLAG_EN
    logic [1:0] sat_q;
    assign sat_flag = sat_q;
`else
    assign sat_flag = 2'b00;
`endif

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q      <= S_IDLE;
            settle_cnt_q <= '0;
            samp_cnt_q   <= '0;
            acc_g01_q    <= '0;
            acc_g10_q    <= '0;
            bsl_g01_q    <= '0;
            bsl_g10_q    <= '0;
            done_q       <= 1'b0;
`ifdef LDTU_BSL_SAT_FLAG_EN
            sat_q        <= 2'b00;
`endif
        end else begin
            done_q <= 1'b0;
            // abort outranks every busy-state transition, including a final sample or the load itself
            if (state_q != S_IDLE && abort) begin
                state_q      <= S_IDLE;
                settle_cnt_q <= '0;
                samp_cnt_q   <= '0;
                acc_g01_q    <= '0;
                acc_g10_q    <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        settle_cnt_q <= '0;
                        samp_cnt_q   <= '0;
                        acc_g01_q    <= '0;
                        acc_g10_q    <= '0;
                        if (start && !abort) begin
                            state_q <= (SETTLE == 0) ? S_ACCUM : S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (settle_cnt_q == SETTLE_LAST) begin
                            state_q <= S_ACCUM;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + 8'd1;
                        end
                    end
                    S_ACCUM: begin
                        if (sample_valid) begin
                            acc_g01_q  <= acc_g01_q + {{NSAMP_LOG2{1'b0}}, DATA12_g01};
                            acc_g10_q  <= acc_g10_q + {{NSAMP_LOG2{1'b0}}, DATA12_g10};
                            samp_cnt_q <= samp_cnt_q + 1'b1;
                            if (samp_cnt_q == SAMP_LAST) begin
                                state_q <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        bsl_g01_q <= clamp_g01;
                        bsl_g10_q <= clamp_g10;
`ifdef LDTU_BSL_SAT_FLAG_EN
                        sat_q     <= {ovf_g10, ovf_g01};
`endif
                        done_q    <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign BSL_VAL_g01 = bsl_g01_q;
    assign BSL_VAL_g10 = bsl_g10_q;

endmodule

// File: tb/tb_ldtu_bsl_calib.sv
// tb/tb_ldtu_bsl_calib.sv - self-checking bench for ldtu_bsl_calib (vector table plus scoreboard of done events)
module tb_ldtu_bsl_calib;

    logic        CLK = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        sample_valid;
    logic [11:0] DATA12_g01;
    logic [11:0] DATA12_g10;
    logic [7:0]  BSL_VAL_g01;
    logic [7:0]  BSL_VAL_g10;
    logic        busy;
    logic        done;
    logic [1:0]  sat_flag;

    ldtu_bsl_calib dut (
        .CLK         (CLK),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .sample_valid(sample_valid),
        .DATA12_g01  (DATA12_g01),
        .DATA12_g10  (DATA12_g10),
        .BSL_VAL_g01 (BSL_VAL_g01),
        .BSL_VAL_g10 (BSL_VAL_g10),
        .busy        (busy),
        .done        (done),
        .sat_flag    (sat_flag)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] g01;
        logic [7:0] g10;
        logic [1:0] sat;
        longint     t;
    } exp_t;

    typedef struct {
        logic [11:0] g01_e;
        logic [11:0] g01_o;
        logic [11:0] g10;
        bit          alt_valid;
        logic [7:0]  e01;
        logic [7:0]  e10;
        logic [1:0]  esat;
        int          lat;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] xsat(input logic [1:0] s);
`ifdef LDTU_BSL_SAT_FLAG_EN
        return s;
`else
        return s & 2'b00;
`endif
    endfunction

    // Every done pulse must match the oldest outstanding expectation, including its arrival time.
    always @(negedge CLK) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at %0t expected no pulse", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_g01", 64'(BSL_VAL_g01), 64'(e.g01));
                check("done_g10", 64'(BSL_VAL_g10), 64'(e.g10));
                check("done_sat", 64'(sat_flag), 64'(e.sat));
                check("done_time", $time, e.t);
                check("done_busy", 64'(busy), 64'd0);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge CLK);
        check("sb_drain", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    task automatic drive_cal(input vec_t v);
        longint t0;
        @(negedge CLK);
        t0    = $time;
        start = 1'b1;
        abort = 1'b0;
        sb.push_back('{g01: v.e01, g10: v.e10, sat: xsat(v.esat), t: t0 + longint'(v.lat) * 10});
        for (int off = 0; off < v.lat; off++) begin
            if (off > 0) @(negedge CLK);
            if (off == 1) start = 1'b0;
            DATA12_g01   = off[0] ? v.g01_o : v.g01_e;
            DATA12_g10   = v.g10;
            sample_valid = v.alt_valid ? !off[0] : 1'b1;
        end
        drain();
    endtask

    task automatic run_abort(input int abort_off, input logic [7:0] prev_g01);
        @(negedge CLK);
        start        = 1'b1;
        DATA12_g01   = 12'h030;
        DATA12_g10   = 12'h030;
        sample_valid = 1'b1;
        for (int off = 1; off <= abort_off; off++) begin
            @(negedge CLK);
            start = 1'b0;
            if (off == abort_off) abort = 1'b1;
        end
        @(negedge CLK);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_g01_held", 64'(BSL_VAL_g01), 64'(prev_g01));
        repeat (30) @(negedge CLK);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t0;
        vecs[0] = '{12'h040, 12'h040, 12'h3FF, 1'b0, 8'h40, 8'hFF, 2'b10, 26};
        vecs[1] = '{12'd100, 12'd101, 12'h000, 1'b0, 8'd100, 8'h00, 2'b00, 26};
        vecs[2] = '{12'h040, 12'h040, 12'h3FF, 1'b1, 8'h40, 8'hFF, 2'b10, 42};
        vecs[3] = '{12'h0FF, 12'h0FF, 12'h100, 1'b0, 8'hFF, 8'hFF, 2'b10, 26};
        vecs[4] = '{12'hFFF, 12'hFFF, 12'h000, 1'b0, 8'hFF, 8'h00, 2'b01, 26};

        rst = 1'b1; start = 1'b0; abort = 1'b0; sample_valid = 1'b0;
        DATA12_g01 = '0; DATA12_g10 = '0;
        repeat (2) @(negedge CLK);
        check("rst_g01", 64'(BSL_VAL_g01), 64'd0);
        check("rst_g10", 64'(BSL_VAL_g10), 64'd0);
        check("rst_sat", 64'(sat_flag), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 5; i++) drive_cal(vecs[i]);

        // abort after five samples, then abort racing the final sample
        drive_cal('{12'h020, 12'h020, 12'h010, 1'b0, 8'h20, 8'h10, 2'b00, 26});
        run_abort(14, 8'h20);
        run_abort(24, 8'h20);
        drive_cal('{12'h030, 12'h030, 12'h010, 1'b0, 8'h30, 8'h10, 2'b00, 26});

        // start held high: one done per run, second run accepted in the done cycle
        @(negedge CLK);
        t0 = $time;
        start = 1'b1; DATA12_g01 = 12'h011; DATA12_g10 = 12'h022; sample_valid = 1'b1;
        sb.push_back('{g01: 8'h11, g10: 8'h22, sat: 2'b00, t: t0 + 260});
        sb.push_back('{g01: 8'h11, g10: 8'h22, sat: 2'b00, t: t0 + 520});
        repeat (27) @(negedge CLK);
        start = 1'b0;
        drain();

        // start with abort in IDLE is refused
        @(negedge CLK);
        start = 1'b1; abort = 1'b1;
        @(negedge CLK);
        check("start_abort_busy", 64'(busy), 64'd0);
        start = 1'b0; abort = 1'b0;
        @(negedge CLK);
        check("start_abort_busy2", 64'(busy), 64'd0);

        // reset during ACCUM wipes a previous baseline
        drive_cal('{12'h055, 12'h055, 12'h055, 1'b0, 8'h55, 8'h55, 2'b00, 26});
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (11) @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        check("midrst_g01", 64'(BSL_VAL_g01), 64'd0);
        check("midrst_g10", 64'(BSL_VAL_g10), 64'd0);
        check("midrst_sat", 64'(sat_flag), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        rst = 1'b0;
        repeat (30) @(negedge CLK);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ldtu_bsl_calib.md
# ldtu_bsl_calib

Baseline calibration sequencer for the LiTe-DTU front end. On a start request it waits a programmable settling time, then accumulates a power-of-two number of ADC samples from both gain channels. It computes the truncated mean of each channel, saturates it to 8 bits and loads the results as the baseline values consumed by the baseline-subtraction stage (BSL_VAL_g01 / BSL_VAL_g10). Sits between the slow-control/calibration logic and the baseline-subtraction datapath.

## Interface

Parameters:
- Nbits_12, 12, ADC sample width
- Nbits_8, 8, baseline value width
- NSAMP_LOG2, 4, log2 of samples averaged per channel (1..8)
- SETTLE, 8, settling cycles after start before accumulation (0..255)

Ports:
- CLK  in  1  block clock; one clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  calibration request, sampled in IDLE only
- abort  in  1  cancel a running calibration
- sample_valid  in  1  DATA12_g01/DATA12_g10 hold a new sample this cycle
- DATA12_g01  in  Nbits_12  gain-1 ADC sample
- DATA12_g10  in  Nbits_12  gain-10 ADC sample
- BSL_VAL_g01  out  Nbits_8  gain-1 baseline value (registered)
- BSL_VAL_g10  out  Nbits_8  gain-10 baseline value (registered)
- busy  out  1  high in SETTLE, ACCUM and LOAD
- done  out  1  one-cycle pulse; new baseline values valid
- sat_flag  out  2  bit0 = g01 mean saturated, bit1 = g10 mean saturated

## Operation

- States: IDLE, SETTLE, ACCUM, LOAD.
- IDLE:
  - start=1 and abort=0 → SETTLE, or → ACCUM if SETTLE=0.
  - Settle counter, sample counter and both accumulators are cleared on entry.
- SETTLE: counts SETTLE cycles with samples ignored, then → ACCUM.
- ACCUM:
  - On each cycle with sample_valid=1, add the sample to its channel accumulator (width Nbits_12+NSAMP_LOG2, no overflow possible) and increment the sample counter.
  - After the 2^NSAMP_LOG2-th valid sample → LOAD.
  - Cycles with sample_valid=0 stall; there is no timeout.
- LOAD, one cycle:
  - mean = acc >> NSAMP_LOG2, truncated.
  - If mean > 255, the baseline is 255 and the channel's saturation bit is set; otherwise the baseline is mean[7:0] and the bit is clear.
  - BSL_VAL_g01, BSL_VAL_g10 and sat_flag are written on the same edge. done is registered high on that edge, and the state returns to IDLE.
- BSL_VAL_* and sat_flag hold their values between calibrations. They change only on a LOAD edge or on reset.
- start is ignored while busy=1.
- abort while busy=1:
  - Next state is IDLE and accumulators are cleared.
  - BSL_VAL_*, sat_flag are unchanged and no done pulse is issued.
  - abort takes priority over a concurrent last valid sample.
- start and abort together in IDLE: abort wins and the state remains IDLE.
- A start sampled in the cycle where done=1 is accepted, because the state is already IDLE.

## Timing

- Reset (rst=1 at an edge): state IDLE, BSL_VAL_g01=0, BSL_VAL_g10=0, sat_flag=0, busy=0, done=0, counters and accumulators 0. Reset mid-calibration discards everything.
- busy goes high in the cycle after start is sampled.
- With sample_valid held high, done goes high SETTLE + 2^NSAMP_LOG2 + 2 cycles after the start cycle. With defaults this is 26 cycles.
- Each sample_valid=0 cycle in ACCUM adds one cycle of latency.
- done is high for exactly one cycle, and busy=0 in that cycle. The new BSL_VAL_* are visible in the same cycle as done.

## Configuration

- LDTU_BSL_SAT_FLAG_EN defined: the saturation detect logic is built and sat_flag is driven as described.
- LDTU_BSL_SAT_FLAG_EN undefined:
  - sat_flag is tied to 2'b00.
  - Clamping to 255 still applies.
  - The port list is unchanged.

## Test plan

- Defaults; DATA12_g01=0x040 and DATA12_g10=0x3FF constant; valid always high; pulse start → done at cycle 26, BSL_VAL_g01=0x40, BSL_VAL_g10=0xFF, sat_flag=2'b10. Without the macro, sat_flag=2'b00.
- g01 alternating 100/101 with g10=0 → BSL_VAL_g01=100 (sum 1608 >> 4), BSL_VAL_g10=0, sat_flag=0.
- sample_valid high only every other cycle → done at cycle 42, with the same values as in the first scenario.
- Complete a calibration (g01=0x20), then start a second with g01=0x30 and assert abort after 5 samples → no done pulse, busy drops next cycle, BSL_VAL_g01 stays 0x20. A new start then completes normally.
- start held high throughout a run → exactly one done; a second calibration starts in the done cycle. start together with abort in IDLE → busy stays 0.
- Assert rst during ACCUM after a prior calibration of 0x55 → next cycle BSL_VAL_*=0, sat_flag=0, busy=0, done=0.
